// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: 3x3 window of unsigned pixels times a signed 3x3 kernel, clamped to pixel range
// Latency: 3 cycles from accept to out_valid; one result per cycle while out_ready stays high
// Backpressure: out_ready low freezes S3 and outputs; earlier stages fill bubbles; in_ready falls only when S1..S3 all full
module conv_mac_pipe #(
    parameter int PIX_W  = 4,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9*PIX_W-1:0] samp_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               coef_wr,
    input  logic [3:0]         coef_idx,
    input  logic [COEF_W-1:0]  coef_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   pix_out,
    output logic [15:0]        sum_out,
    output logic               sat_flag,
    input  logic               sat_clr,
    output logic [15:0]        res_count
);

    localparam int PROD_W = PIX_W + COEF_W;   // pixel (zero-extended) times coefficient
    localparam int PSUM_W = PROD_W + 2;       // sum of three products
    localparam int SUM_W  = 16;               // sum of nine products, never overflows
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

    // Zero-extend the pixel, sign-extend the coefficient, multiply in PROD_W bits.
    function automatic logic signed [PROD_W-1:0] mul_pix(input logic [PIX_W-1:0] p,
                                                         input logic signed [COEF_W-1:0] c);
        logic signed [PROD_W-1:0] pe;
        logic signed [PROD_W-1:0] ce;
        pe = $signed({{COEF_W{1'b0}}, p});
        ce = {{PIX_W{c[COEF_W-1]}}, c};
        return pe * ce;
    endfunction

    function automatic logic signed [PSUM_W-1:0] ext_psum(input logic signed [PROD_W-1:0] v);
        return {{(PSUM_W-PROD_W){v[PROD_W-1]}}, v};
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_sum(input logic signed [PSUM_W-1:0] v);
        return {{(SUM_W-PSUM_W){v[PSUM_W-1]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Kernel storage
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0] coef_q [9];

    // Kernel store: identity after reset; a write lands on the next edge, indices 9..15 match nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                coef_q[k] <= (k == 4) ? COEF_W'(1) : '0;
        end else if (coef_wr) begin
            for (int k = 0; k < 9; k++)
                if (coef_idx == 4'(k))
                    coef_q[k] <= coef_data;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline handshake
    // ------------------------------------------------------------------
    logic s1_vld_q, s2_vld_q, s3_vld_q;
    logic s1_en, s2_en, s3_en, xfer;

    // Each stage may load when it is empty or when its contents move on this cycle
    always_comb begin
        s3_en = !s3_vld_q || out_ready;
        s2_en = !s2_vld_q || s3_en;
        s1_en = !s1_vld_q || s2_en;
        xfer  = s3_vld_q && out_ready;
    end

    assign in_ready = s1_en;

    // ------------------------------------------------------------------
    // Stage 1: nine products
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_d    [9];
    logic signed [PROD_W-1:0] s1_prod_q [9];

    // Products use the kernel as it stands in the accept cycle, so a same-cycle write is not yet visible
    always_comb begin
        for (int k = 0; k < 9; k++)
            prod_d[k] = mul_pix(samp_in[k*PIX_W +: PIX_W], coef_q[k]);
    end

    // S1 register: capture products when a sample is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            for (int k = 0; k < 9; k++)
                s1_prod_q[k] <= '0;
        end else if (s1_en) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < 9; k++)
                    s1_prod_q[k] <= prod_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: three row sums
    // ------------------------------------------------------------------
    logic signed [PSUM_W-1:0] psum_d    [3];
    logic signed [PSUM_W-1:0] s2_psum_q [3];

    // One partial sum per kernel row
    always_comb begin
        for (int j = 0; j < 3; j++)
            psum_d[j] = ext_psum(s1_prod_q[3*j]) + ext_psum(s1_prod_q[3*j+1])
                      + ext_psum(s1_prod_q[3*j+2]);
    end

    // S2 register: capture row sums when S1 holds valid data and S2 can load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            for (int j = 0; j < 3; j++)
                s2_psum_q[j] <= '0;
        end else if (s2_en) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                for (int j = 0; j < 3; j++)
                    s2_psum_q[j] <= psum_d[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: total, shift and clamp
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] shifted;
    logic [PIX_W-1:0]        pix_d;
    logic                    sat_d;

    // Total sum, then clamp the shifted value into 0..2^PIX_W-1 and note whether clamping happened
    always_comb begin
        sum_d   = ext_sum(s2_psum_q[0]) + ext_sum(s2_psum_q[1]) + ext_sum(s2_psum_q[2]);
        shifted = sum_d >>> SHIFT;
        if (shifted[SUM_W-1]) begin
            pix_d = '0;
            sat_d = 1'b1;
        end else if (shifted > PIX_MAX) begin
            pix_d = PIX_MAX[PIX_W-1:0];
            sat_d = 1'b1;
        end else begin
            pix_d = shifted[PIX_W-1:0];
            sat_d = 1'b0;
        end
    end

    logic signed [SUM_W-1:0] sum_q;
    logic [PIX_W-1:0]        pix_q;
    logic                    s3_sat_q;

    // S3 register: holds result and outputs stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_vld_q <= 1'b0;
            sum_q    <= '0;
            pix_q    <= '0;
            s3_sat_q <= 1'b0;
        end else if (s3_en) begin
            s3_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                sum_q    <= sum_d;
                pix_q    <= pix_d;
                s3_sat_q <= sat_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: sticky saturation flag and hand-off counter
    // ------------------------------------------------------------------
    logic        sat_flag_q, sat_flag_d;
    logic [15:0] res_count_q, res_count_d;

    // Clear wins over a same-cycle set; the counter wraps naturally at 16 bits
    always_comb begin
        sat_flag_d  = sat_flag_q;
        res_count_d = res_count_q;
        if (sat_clr)
            sat_flag_d = 1'b0;
        else if (xfer && s3_sat_q)
            sat_flag_d = 1'b1;
        if (xfer)
            res_count_d = res_count_q + 16'd1;
    end

    // Status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag_q  <= 1'b0;
            res_count_q <= '0;
        end else begin
            sat_flag_q  <= sat_flag_d;
            res_count_q <= res_count_d;
        end
    end

    assign out_valid = s3_vld_q;
    assign sum_out   = sum_q;
    assign pix_out   = pix_q;
    assign sat_flag  = sat_flag_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: directed stimulus with a result scoreboard for conv_mac_pipe
// Stimulus pushes expected {sum,pix} on accept; a monitor pops on every output transfer
// out_ready is driven by a mode variable: held low, held high, or toggling each cycle
module tb_conv_mac_pipe;

    localparam int SHIFT = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] samp_in;
    logic        in_valid;
    logic        in_ready;
    logic        coef_wr;
    logic [3:0]  coef_idx;
    logic [7:0]  coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  pix_out;
    logic [15:0] sum_out;
    logic        sat_flag;
    logic        sat_clr;
    logic [15:0] res_count;

    conv_mac_pipe #(.PIX_W(4), .COEF_W(8), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst       (rst),
        .samp_in   (samp_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coef_wr   (coef_wr),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pix_out   (pix_out),
        .sum_out   (sum_out),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr),
        .res_count (res_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_q [$];          // {sum[15:0], pix[3:0]}
    int rdy_mode = 1;                // 0 low, 1 high, 2 toggle
    logic signed [7:0] kern [9];     // bench copy of the kernel, used only for the stream test

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] model(input logic [35:0] w);
        int s;
        int sh;
        int c;
        logic [3:0] p;
        s = 0;
        for (int k = 0; k < 9; k++) begin
            c = kern[k];
            s += int'(w[4*k +: 4]) * c;
        end
        sh = s >>> SHIFT;
        if (sh < 0)       p = 4'h0;
        else if (sh > 15) p = 4'hF;
        else              p = sh[3:0];
        return {s[15:0], p};
    endfunction

    task automatic kern_identity();
        for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 8'sd1 : 8'sd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [35:0] w, input logic [19:0] e);
        bit done;
        done = 0;
        samp_in  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, expected 1");
        end
    endtask

    task automatic write_coef(input logic [3:0] idx, input logic [7:0] d);
        coef_wr   = 1'b1;
        coef_idx  = idx;
        coef_data = d;
        tick();
        coef_wr = 1'b0;
        if (idx <= 4'd8) kern[idx] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        kern_identity();
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        tick();
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ~out_ready;
            endcase
        end
    end

    // Monitor: pop and compare on each transfer; outputs must hold while stalled
    initial begin
        logic        stall;
        logic [19:0] held;
        logic [19:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'({sum_out, pix_out}), 32'(held));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_sum", 32'(sum_out), 32'(e[19:4]));
                        chk("result_pix", 32'(pix_out), 32'(e[3:0]));
                    end
                end
                stall = out_valid && !out_ready;
                held  = {sum_out, pix_out};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        samp_in   = '0;
        in_valid  = 1'b0;
        coef_wr   = 1'b0;
        coef_idx  = '0;
        coef_data = '0;
        sat_clr   = 1'b0;
        out_ready = 1'b1;
        rdy_mode  = 1;
        kern_identity();

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pix_out",   32'(pix_out),   32'd0);
        chk("rst_sum_out",   32'(sum_out),   32'd0);
        chk("rst_sat_flag",  32'(sat_flag),  32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: identity kernel passes the centre pixel; check 3-cycle latency
        send(36'hFFFFAFFFF, {16'd10, 4'hA});
        @(negedge clk); chk("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk); chk("latency_c2", 32'(out_valid), 32'd0);
        @(negedge clk); chk("latency_c3", 32'(out_valid), 32'd1);
        drain();
        chk("t1_sat_flag",  32'(sat_flag),  32'd0);
        chk("t1_res_count", 32'(res_count), 32'd1);

        // 2: all-ones kernel, all-0xF window saturates high; sat_clr clears the flag
        for (int k = 0; k < 9; k++) write_coef(4'(k), 8'd1);
        send(36'hFFFFFFFFF, {16'd135, 4'hF});
        drain();
        chk("t2_sat_set", 32'(sat_flag), 32'd1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("t2_sat_clr", 32'(sat_flag), 32'd0);

        // 3: most negative coefficient on pixel 0 saturates low
        write_coef(4'd0, 8'h80);
        for (int k = 1; k < 9; k++) write_coef(4'(k), 8'd0);
        send(36'h00000000F, {16'hF880, 4'h0});
        drain();
        chk("t3_sat_set",   32'(sat_flag),  32'd1);
        chk("t3_res_count", 32'(res_count), 32'd3);

        // 4: 20 back-to-back windows with out_ready toggling, kernel coef_k = k-4
        do_reset();
        for (int k = 0; k < 9; k++) write_coef(4'(k), 8'(k - 4));
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            logic [35:0] w;
            for (int k = 0; k < 9; k++) w[4*k +: 4] = 4'((i + k) & 15);
            send(w, model(w));
        end
        drain();
        rdy_mode = 1;
        tick();
        chk("t4_res_count", 32'(res_count), 32'd20);

        // 5: kernel write in the accept cycle affects only the next sample; idx 12 ignored
        do_reset();
        coef_wr   = 1'b1;
        coef_idx  = 4'd4;
        coef_data = 8'd2;
        send(36'h000030000, {16'd3, 4'd3});
        coef_wr = 1'b0;
        send(36'h000030000, {16'd6, 4'd6});
        write_coef(4'd12, 8'd5);
        send(36'h000030000, {16'd6, 4'd6});
        drain();
        chk("t5_res_count", 32'(res_count), 32'd3);

        // 6: reset with three samples in flight drops them and restores the identity kernel
        write_coef(4'd4, 8'd5);
        rdy_mode = 0;
        tick();
        send(36'h000010000, {16'd5, 4'd5});
        send(36'h000020000, {16'd10, 4'd10});
        send(36'h000030000, {16'd15, 4'd15});
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_res_count", 32'(res_count), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        kern_identity();
        rdy_mode = 1;
        tick();
        send(36'hFFFF7FFFF, {16'd7, 4'd7});
        drain();
        chk("t6_after_count", 32'(res_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
